mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  MEM stage between the EX/MEM and MEM/WB pipeline registers. Drives a req/ack data-memory port.
//  Stalls the front of the pipe until the access completes.
//  Selects the write-back value (ALU result, load data, or NPC for CALL) and hands it to MEM/WB.
// PARAMETERS
//  ADDR_W   16  data-memory word-address width; dmem_addr = ALUout_MEM[ADDR_W-1:0]
//  TIMEOUT  64  max cycles in BUSY without ack (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  RegWr_MEM    in   1       from EX/MEM: register write enable
//  MemWr_MEM    in   1       from EX/MEM: store
//  MemRd_MEM    in   1       from EX/MEM: load
//  WBdata_MEM   in   2       write-back select: 00 ALU, 01 mem, 10 NPC, 11 reserved (= ALU)
//  ALUout_MEM   in   32      effective address / ALU result
//  D_MEM        in   32      store data
//  NPC_MEM      in   32      PC+1 (CALL link value)
//  Rd_MEM       in   5       destination register
//  dmem_req     out  1       memory request, held high until ack
//  dmem_we      out  1       1 = write
//  dmem_addr    out  ADDR_W  word address
//  dmem_wdata   out  32      store data
//  dmem_rdata   in   32      load data, valid with ack
//  dmem_ack     in   1       one-cycle completion pulse
//  mem_stall    out  1       freeze PC, IF/ID, ID/EX and EX/MEM this cycle
//  RegWrite_o   out  1       to MEM/WB RegWrite; forced 0 while mem_stall
//  Rd_o         out  5       to MEM/WB Rd (= Rd_MEM)
//  Data_o       out  32      to MEM/WB Data
//  mem_err      out  1       sticky timeout flag (0 when MEM_TIMEOUT_EN is undefined)
// BEHAVIOUR
//  - access = MemRd_MEM | MemWr_MEM. FSM states: IDLE, BUSY, DONE.
//  - IDLE, !access: mem_stall=0; pass-through with 0 added latency; stay in IDLE.
//  - IDLE, access: mem_stall=1. Register dmem_addr, dmem_wdata=D_MEM, dmem_we=MemWr_MEM. Next state BUSY.
//  - BUSY: dmem_req=1; mem_stall=1; address, data and we held stable.
//    - On dmem_ack: if !dmem_we, latch dmem_rdata into rdata_q. Drop req at that edge. Next state DONE.
//  - DONE: mem_stall=0; Data_o uses rdata_q; next state IDLE.
//    - MEM/WB captures at this edge; EX/MEM loads the next instruction at the same edge.
//  - Minimum access = 3 cycles (ack in first BUSY cycle) = 2 stall cycles. No upper bound without timeout.
//  - Data_o: 01 -> rdata_q (in DONE) | 10 -> NPC_MEM | 00/11 -> ALUout_MEM.
//  - RegWrite_o = RegWr_MEM & ~mem_stall, so a bubble enters MEM/WB on stall cycles.
//  - MemRd and MemWr both set: write wins (dmem_we=1); rdata_q not updated.
//  - dmem_ack in IDLE or DONE: ignored.
//  - Reset (any state, including mid-BUSY): state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0,
//    dmem_wdata=0, rdata_q=0, mem_err=0. Combinational outputs then follow their inputs.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - Counter runs in BUSY; clears on entering BUSY.
//   - When the count reaches TIMEOUT-1 with no ack: treat as ack with rdata=0, set mem_err (sticky until rst),
//     go to DONE.
//   - Ack on the terminal cycle counts as a normal ack; mem_err is not set.
//  MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; mem_err tied 0.
// STRUCTURE
//  Shared package/header mem_stage_defs:
//   - state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
//   - WBdata encodings (WB_ALU=2'b00, WB_MEM=2'b01, WB_NPC=2'b10)
//  Sub-module mem_wait_timer (count, clear, expire; parameter TIMEOUT). Instantiated only under MEM_TIMEOUT_EN.
//  FSM, address/data registers and write-back mux stay in this module.
// TESTING
//  1 ALU op (RegWr=1, WBdata=00, ALUout=0x1234, Rd=5) in IDLE -> same cycle: stall=0, Data_o=0x1234,
//    RegWrite_o=1, Rd_o=5.
//  2 Load (MemRd=1, WBdata=01, ALUout=0x40), ack after 3 BUSY cycles, rdata=0xCAFEF00D:
//    - req high 3 cycles with addr=0x40; stall high 4 cycles; RegWrite_o=0 while stalled.
//    - Then DONE: Data_o=0xCAFEF00D, RegWrite_o=1.
//  3 Store (MemWr=1, ALUout=0x10, D=0xA5A5A5A5), ack in first BUSY cycle:
//    - we=1, wdata=0xA5A5A5A5, req 1 cycle, stall 2 cycles, rdata_q unchanged.
//  4 CALL (WBdata=10, NPC=0x0000_0021, RegWr=1) -> Data_o=0x21 immediately, no request issued.
//  5 rst asserted mid-BUSY (asynchronous, between edges):
//    - req=0, state=IDLE immediately.
//    - Late ack after rst release: ignored, Data_o unaffected.
//  6 With MEM_TIMEOUT_EN and TIMEOUT=8, load with no ack:
//    - 8 BUSY cycles, then DONE with Data_o=0 and mem_err=1.
//    - mem_err stays 1 through subsequent loads until rst.

Source files
------------

// File: rtl/mem_stage_defs_pkg.sv
// Shared encodings for the MEM pipeline stage: access FSM states and write-back source select.
package mem_stage_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_NPC = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Cycle counter bounding how long the MEM stage waits for a data-memory ack.
// o_expire fires on the counting cycle whose count equals TIMEOUT-1.
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_count) r_count <= r_count + 1'b1;
  end

  assign o_expire = i_count && (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives a req/ack data-memory port, stalls the front of the pipe during an access,
// and selects the write-back value. Define MEM_TIMEOUT_EN to bound the wait with a sticky mem_err.
module mem_access_stage
  import mem_stage_defs::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWr_MEM,
  input  logic              MemWr_MEM,
  input  logic              MemRd_MEM,
  input  logic [1:0]        WBdata_MEM,
  input  logic [31:0]       ALUout_MEM,
  input  logic [31:0]       D_MEM,
  input  logic [31:0]       NPC_MEM,
  input  logic [4:0]        Rd_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              RegWrite_o,
  output logic [4:0]        Rd_o,
  output logic [31:0]       Data_o,
  output logic              mem_err
);

  state_t              r_state;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata_q;
  logic                r_err;
  logic                w_access;
  logic                w_expire;
  logic                w_unused;

  assign w_access = MemRd_MEM | MemWr_MEM;
  // Upper address bits beyond the word-address width are deliberately dropped.
  assign w_unused = &{1'b0, ALUout_MEM[31:ADDR_W], TIMEOUT[0]};

`ifdef MEM_TIMEOUT_EN
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  ((r_state == IDLE) && w_access),
    .i_count  (r_state == BUSY),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata_q <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_access) begin
          r_state <= BUSY;
          r_req   <= 1'b1;
          r_we    <= MemWr_MEM;
          r_addr  <= ALUout_MEM[ADDR_W-1:0];
          r_wdata <= D_MEM;
        end
        BUSY: if (dmem_ack || w_expire) begin
          // A real ack on the terminal cycle wins over the timeout.
          r_state <= DONE;
          r_req   <= 1'b0;
          if (!r_we) r_rdata_q <= dmem_ack ? dmem_rdata : 32'h0;
          if (!dmem_ack) r_err <= 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign mem_err    = r_err;

  assign mem_stall  = (r_state == BUSY) || ((r_state == IDLE) && w_access);
  assign RegWrite_o = RegWr_MEM & ~mem_stall;
  assign Rd_o       = Rd_MEM;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    Data_o = ALUout_MEM;
    case (WBdata_MEM)
      WB_MEM:  Data_o = r_rdata_q;
      WB_NPC:  Data_o = NPC_MEM;
      default: Data_o = ALUout_MEM;
    endcase
  end

endmodule
